flag_fifo: RTL and testbench
============================

# flag_fifo

Parametrised single-clock show-ahead FIFO, the successor to the team's basic FIFO. Adds a synchronous flush, programmable almost-full/almost-empty thresholds, a correctly sized occupancy count and optional sticky overflow/underflow error flags. It sits between stream producers and consumers in generated datapaths, where back-pressure must act before the FIFO is full.

## Interface
Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 8, log2 of entry count; FIFO_SIZE = 2**DEPTH. Legal range 1..16.
- AFULL_MARGIN, 4, almost_full threshold; asserts when count >= FIFO_SIZE - AFULL_MARGIN. Legal range 1..FIFO_SIZE-1.
- AEMPTY_MARGIN, 4, almost_empty threshold; asserts when count <= AEMPTY_MARGIN. Legal range 0..FIFO_SIZE-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous flush, active-high.
- we  in  1  write request.
- din  in  WIDTH  write data.
- re  in  1  read request (acknowledge of current dout).
- dout  out  WIDTH  head-of-queue data, combinational from memory at the read pointer.
- empty  out  1  registered; no entries.
- full  out  1  registered; FIFO_SIZE entries.
- almost_empty  out  1  registered threshold flag.
- almost_full  out  1  registered threshold flag.
- count  out  DEPTH+1  registered occupancy, 0..FIFO_SIZE.
- overflow  out  1  sticky; write attempted while full.
- underflow  out  1  sticky; read attempted while empty.

## Operation
- Storage: FIFO_SIZE x WIDTH array, not reset. Pointers head (write) and tail (read) are DEPTH bits wide and wrap modulo FIFO_SIZE. A looped bit distinguishes full from empty when head == tail.
- Priority per cycle: reset > clear > read/write.
- reset or clear: head = tail = 0, looped = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0. re and we in the same cycle are ignored; memory is untouched.
- Read is evaluated first: when re = 1 and the FIFO is not empty, tail advances; when tail wraps from FIFO_SIZE-1 to 0, looped clears.
- Write is evaluated second, against the post-read state: when we = 1 and the FIFO is not full, mem[head] = din and head advances; when head wraps, looped sets.
- Simultaneous re and we when full: both succeed and count is unchanged.
- Simultaneous re and we when empty: the read is rejected (underflow sets) and the write succeeds, so count = 1.
- Rejected write: data is dropped and overflow sets. Rejected read: pointers are unchanged and underflow sets. Both flags hold until reset or clear.
- All flags and count are computed from the post-operation pointers and registered.
- count = head - tail modulo FIFO_SIZE, or FIFO_SIZE when head == tail and looped = 1.

## Timing
- Write latency: data written at edge N appears on dout after edge N when the FIFO was empty; empty deasserts and count increments at that same edge.
- Read: dout is valid whenever empty = 0. Asserting re consumes the word at the next edge, after which dout shows the next entry.
- dout is don't-care while empty = 1.
- Flags have one-cycle latency relative to the request. There is no combinational path from we/re to any flag.
- Throughput: one write and one read per cycle, sustained.
- Reset and clear take effect at the edge where they are sampled. All outputs are at reset values after that edge.

## Configuration
- FLAG_FIFO_ERR_FLAGS_EN defined: overflow and underflow are implemented as described above.
- FLAG_FIFO_ERR_FLAGS_EN undefined: overflow and underflow are constant 0 and no sticky registers are built. All other behaviour is identical.

## Test plan
Bench parameters: WIDTH=8, DEPTH=3, AFULL_MARGIN=2, AEMPTY_MARGIN=2, FLAG_FIFO_ERR_FLAGS_EN defined.
- Reset, then idle for 3 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, count=0, overflow=0, underflow=0.
- Write 0x01..0x08 on consecutive cycles -> count steps 1..8; almost_empty drops when count=3; almost_full rises when count=6; full=1 at count=8. A 9th write of 0xFF -> overflow=1, count stays 8.
- From full, hold re and we together for 4 cycles with din 0xA0..0xA3 -> count stays 8; dout shows 0x01..0x04 then 0x05. Drain all entries -> order is 0x05..0x08, 0xA0..0xA3 (pointer wrap verified).
- On an empty FIFO, re=1 with we=1 and din=0x5A -> underflow=1, count=1, dout=0x5A on the next cycle.
- Load 5 entries, then pulse clear together with we=1 -> count=0, empty=1, overflow=underflow=0; the write is dropped.
- Assert reset mid-stream while re and we are both active -> reset values on the next cycle; a subsequent write of 0x33 is read back first.

Source files
------------

// File: rtl/flag_fifo_if.sv
// Handshake bundle for flag_fifo: write/read requests, data and status flags.
// The FIFO uses the slave modport; the producer/consumer side uses master.
interface flag_fifo_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
);
   logic             clear;
   logic             we;
   logic [WIDTH-1:0] din;
   logic             re;
   logic [WIDTH-1:0] dout;
   logic             empty;
   logic             full;
   logic             almost_empty;
   logic             almost_full;
   logic [DEPTH:0]   count;
   logic             overflow;
   logic             underflow;

   modport master (
      output clear, we, din, re,
      input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  clear, we, din, re,
      output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/flag_fifo.sv
// Single-clock show-ahead FIFO with flush, threshold flags and occupancy count.
// Define FLAG_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module flag_fifo #(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned DEPTH         = 8,
   parameter int unsigned AFULL_MARGIN  = 4,
   parameter int unsigned AEMPTY_MARGIN = 4
) (
   input logic         clk,
   input logic         reset,
   flag_fifo_if.slave  bus
);
   localparam int unsigned FIFO_SIZE = 2 ** DEPTH;
   localparam int unsigned CW        = DEPTH + 1;
   localparam logic [DEPTH:0] FULL_CNT   = CW'(FIFO_SIZE);
   localparam logic [DEPTH:0] AFULL_CNT  = CW'(FIFO_SIZE - AFULL_MARGIN);
   localparam logic [DEPTH:0] AEMPTY_CNT = CW'(AEMPTY_MARGIN);

   logic [WIDTH-1:0] mem_q [FIFO_SIZE];

   logic [DEPTH-1:0] head_q, head_d, tail_q, tail_d, ptr_diff;
   logic             looped_q, looped_d;
   logic [DEPTH:0]   count_q, count_d;
   logic             empty_q, empty_d, full_q, full_d;
   logic             aempty_q, aempty_d, afull_q, afull_d;
   logic             flush, rd_ok, wr_ok;

   always_comb begin
      flush = reset | bus.clear;
      rd_ok = bus.re & ~empty_q & ~flush;
      // Write sees the post-read state, so a read frees the slot of a full FIFO.
      wr_ok = bus.we & ~(full_q & ~rd_ok) & ~flush;

      head_d   = head_q;
      tail_d   = tail_q;
      looped_d = looped_q;
      if (flush) begin
         head_d   = '0;
         tail_d   = '0;
         looped_d = 1'b0;
      end else begin
         if (rd_ok) begin
            tail_d = tail_q + DEPTH'(1);
            if (tail_q == '1) looped_d = 1'b0;
         end
         if (wr_ok) begin
            head_d = head_q + DEPTH'(1);
            if (head_q == '1) looped_d = 1'b1;
         end
      end

      ptr_diff = head_d - tail_d;
      count_d  = (looped_d && ptr_diff == '0) ? FULL_CNT : {1'b0, ptr_diff};
      empty_d  = (count_d == '0);
      full_d   = (count_d == FULL_CNT);
      aempty_d = (count_d <= AEMPTY_CNT);
      afull_d  = (count_d >= AFULL_CNT);
   end

   always_ff @(posedge clk) begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      looped_q <= looped_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[head_q] <= bus.din;
   end

   assign bus.dout         = mem_q[tail_q];
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.almost_empty = aempty_q;
   assign bus.almost_full  = afull_q;
   assign bus.count        = count_q;

`ifdef FLAG_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d, unf_q, unf_d;

   always_comb begin
      ovf_d = ~flush & (ovf_q | (bus.we & ~wr_ok));
      unf_d = ~flush & (unf_q | (bus.re & empty_q));
   end

   always_ff @(posedge clk) begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`else
   assign bus.overflow  = 1'b0;
   assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_flag_fifo.sv
// Self-checking bench for flag_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_flag_fifo;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned SIZE  = 8;
`ifdef FLAG_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   flag_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   flag_fifo #(
      .WIDTH        (WIDTH),
      .DEPTH        (DEPTH),
      .AFULL_MARGIN (2),
      .AEMPTY_MARGIN(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
      bus.we = w; bus.din = d; bus.re = r; bus.clear = c; reset = rs;
      @(posedge clk);
      if (rs || c) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (r) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_unf = 1'b1;
         end
         if (w) begin
            if (mq.size() < SIZE) mq.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      #1;
      bus.we = 1'b0; bus.re = 1'b0; bus.clear = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.count,
           bus.overflow, bus.underflow} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got e=%b ae=%b f=%b af=%b cnt=%0d ovf=%b unf=%b, expected 1 1 0 0 0 0 0",
                  bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.count,
                  bus.overflow, bus.underflow);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         checks++;
         if ({bus.count, bus.almost_empty, bus.almost_full, bus.full, bus.empty, bus.dout} !==
             {4'(i), i <= 2, i >= 6, i == 8, 1'b0, 8'h01}) begin
            errors++;
            $display("FAIL fill_%0d: got cnt=%0d ae=%b af=%b f=%b e=%b dout=%h, expected cnt=%0d ae=%b af=%b f=%b e=0 dout=01",
                     i, bus.count, bus.almost_empty, bus.almost_full, bus.full, bus.empty, bus.dout,
                     i, i <= 2, i >= 6, i == 8);
         end
      end
      step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.overflow, bus.count, bus.full} !== {ERR_EN, 4'd8, 1'b1}) begin
         errors++;
         $display("FAIL overflow_write: got ovf=%b cnt=%0d f=%b, expected ovf=%b cnt=8 f=1",
                  bus.overflow, bus.count, bus.full, ERR_EN);
      end
   endtask

   task automatic test_full_rw();
      logic [7:0] exp_order [8];
      exp_order = '{8'h05, 8'h06, 8'h07, 8'h08, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.dout !== 8'(k + 1)) begin
            errors++;
            $display("FAIL full_rw_dout_%0d: got %h, expected %h", k, bus.dout, 8'(k + 1));
         end
         step(1'b1, 8'(8'hA0 + k), 1'b1, 1'b0, 1'b0);
         checks++;
         if ({bus.count, bus.full} !== {4'd8, 1'b1}) begin
            errors++;
            $display("FAIL full_rw_count_%0d: got cnt=%0d f=%b, expected cnt=8 f=1",
                     k, bus.count, bus.full);
         end
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (bus.dout !== exp_order[k]) begin
            errors++;
            $display("FAIL drain_%0d: got %h, expected %h", k, bus.dout, exp_order[k]);
         end
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checks++;
      if ({bus.empty, bus.count} !== {1'b1, 4'd0}) begin
         errors++;
         $display("FAIL drain_empty: got e=%b cnt=%0d, expected e=1 cnt=0", bus.empty, bus.count);
      end
   endtask

   task automatic test_empty_rw();
      step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({bus.underflow, bus.count, bus.empty, bus.dout} !== {ERR_EN, 4'd1, 1'b0, 8'h5A}) begin
         errors++;
         $display("FAIL empty_rw: got unf=%b cnt=%0d e=%b dout=%h, expected unf=%b cnt=1 e=0 dout=5a",
                  bus.underflow, bus.count, bus.empty, bus.dout, ERR_EN);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({bus.count, bus.empty, bus.almost_empty, bus.overflow, bus.underflow} !==
          {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL clear: got cnt=%0d e=%b ae=%b ovf=%b unf=%b, expected 0 1 1 0 0",
                  bus.count, bus.empty, bus.almost_empty, bus.overflow, bus.underflow);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.count, bus.empty} !== {4'd0, 1'b1}) begin
         errors++;
         $display("FAIL clear_drops_write: got cnt=%0d e=%b, expected cnt=0 e=1",
                  bus.count, bus.empty);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
      checks++;
      if ({bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full} !==
          {4'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got cnt=%0d e=%b ae=%b f=%b af=%b, expected 0 1 1 0 0",
                  bus.count, bus.empty, bus.almost_empty, bus.full, bus.almost_full);
      end
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.dout !== 8'h33) begin
         errors++;
         $display("FAIL reset_mid_first: got %h, expected 33", bus.dout);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.dout !== 8'h44) begin
         errors++;
         $display("FAIL reset_mid_second: got %h, expected 44", bus.dout);
      end
   endtask

   task automatic test_random();
      int unsigned n;
      logic [9:0]  exp_st, got_st;
      bit          w, r;
      for (int i = 0; i < 600; i++) begin
         // Alternate write-heavy and read-heavy phases to visit both ends.
         if ((i / 60) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         step(w, 8'($urandom), r, $urandom_range(0, 59) == 0, $urandom_range(0, 149) == 0);
         n = mq.size();
         exp_st = {n == 0, n == SIZE, n <= 2, n >= 6, 4'(n), m_ovf & ERR_EN, m_unf & ERR_EN};
         got_st = {bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.count,
                   bus.overflow, bus.underflow};
         checks++;
         if (got_st !== exp_st) begin
            errors++;
            $display("FAIL random_status_%0d: got e/f/ae/af/cnt/ovf/unf=%b, expected %b",
                     i, got_st, exp_st);
         end
         if (n > 0) begin
            checks++;
            if (bus.dout !== mq[0]) begin
               errors++;
               $display("FAIL random_dout_%0d: got %h, expected %h", i, bus.dout, mq[0]);
            end
         end
      end
   endtask

   initial begin
      bus.clear = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.din = '0;
      test_reset();
      test_fill();
      test_full_rw();
      test_empty_rw();
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      test_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
